// File: rtl/axil_wr_buffer_if.sv
// AXI4-lite write channel bundle (AW, W, B) shared by the upstream and
// downstream sides of the write buffer.
interface axil_wr_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  // Side that issues writes
  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready
  );

  // Side that accepts writes
  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/axil_wr_buffer.sv
// Single-outstanding AXI4-lite write buffer: captures one upstream write,
// reissues it downstream, then returns the downstream B response upstream.
// Every output is driven from a register (or a decode of registers only).
module axil_wr_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic clk,
  input  logic rst,
  axil_wr_buffer_if.slave  s_axil,
  axil_wr_buffer_if.master m_axil
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RESP   = 2'd2,
    RETURN = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDR_WIDTH-1:0] r_m_awaddr;
  logic [2:0]            r_m_awprot;
  logic [DATA_WIDTH-1:0] r_m_wdata;
  logic [STRB_WIDTH-1:0] r_m_wstrb;
  logic                  r_m_awvalid;
  logic                  r_m_wvalid;
  logic                  r_m_bready;
  logic                  r_s_bvalid;
  logic [1:0]            r_s_bresp;

  logic w_idle;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_m_aw_done;
  logic w_m_w_done;
  logic w_m_b_hs;
  logic w_s_b_hs;

  // Upstream readies are decoded from state and held flags only
  assign w_idle         = (r_state == IDLE);
  assign s_axil.awready = w_idle && !r_aw_held;
  assign s_axil.wready  = w_idle && !r_w_held;
  assign s_axil.bvalid  = r_s_bvalid;
  assign s_axil.bresp   = r_s_bresp;

  assign m_axil.awaddr  = r_m_awaddr;
  assign m_axil.awprot  = r_m_awprot;
  assign m_axil.awvalid = r_m_awvalid;
  assign m_axil.wdata   = r_m_wdata;
  assign m_axil.wstrb   = r_m_wstrb;
  assign m_axil.wvalid  = r_m_wvalid;
  assign m_axil.bready  = r_m_bready;

  assign w_aw_hs     = s_axil.awvalid && s_axil.awready;
  assign w_w_hs      = s_axil.wvalid && s_axil.wready;
  // A downstream channel is done once its valid is low or is being accepted now
  assign w_m_aw_done = !r_m_awvalid || m_axil.awready;
  assign w_m_w_done  = !r_m_wvalid || m_axil.wready;
  assign w_m_b_hs    = m_axil.bvalid && r_m_bready;
  assign w_s_b_hs    = r_s_bvalid && s_axil.bready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:   if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) w_state_next = ISSUE;
      ISSUE:  if (w_m_aw_done && w_m_w_done)                       w_state_next = RESP;
      RESP:   if (w_m_b_hs)                                        w_state_next = RETURN;
      RETURN: if (w_s_b_hs)                                        w_state_next = IDLE;
      default:                                                     w_state_next = IDLE;
    endcase
  end

  // Upstream capture straight into the downstream payload registers; they can
  // only load in IDLE, where the downstream valids are low, so they are stable
  // for the whole ISSUE phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_m_awaddr <= '0;
      r_m_awprot <= '0;
      r_m_wdata  <= '0;
      r_m_wstrb  <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held  <= 1'b1;
        r_m_awaddr <= s_axil.awaddr;
        r_m_awprot <= s_axil.awprot;
      end
      if (w_w_hs) begin
        r_w_held  <= 1'b1;
        r_m_wdata <= s_axil.wdata;
        r_m_wstrb <= s_axil.wstrb;
      end
      if (w_s_b_hs) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

  // Downstream AW/W valids: raised together on entry to ISSUE, dropped independently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_awvalid <= 1'b0;
      r_m_wvalid  <= 1'b0;
    end else if (w_idle && w_state_next == ISSUE) begin
      r_m_awvalid <= 1'b1;
      r_m_wvalid  <= 1'b1;
    end else if (r_state == ISSUE) begin
      if (m_axil.awready) r_m_awvalid <= 1'b0;
      if (m_axil.wready)  r_m_wvalid  <= 1'b0;
    end
  end

  // Downstream bready only while waiting for B, so stray responses are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         r_m_bready <= 1'b0;
    else if (r_state == ISSUE && w_state_next == RESP) r_m_bready <= 1'b1;
    else if (w_m_b_hs)                                r_m_bready <= 1'b0;
  end

  // Upstream B: capture downstream response unmodified and hold until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_bvalid <= 1'b0;
      r_s_bresp  <= 2'b00;
    end else if (w_m_b_hs) begin
      r_s_bvalid <= 1'b1;
      r_s_bresp  <= m_axil.bresp;
    end else if (w_s_b_hs) begin
      r_s_bvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_wr_buffer.sv
// Self-checking bench for axil_wr_buffer: directed scenarios plus randomized
// writes, each checked cycle by cycle against a transaction-level model.
module tb_axil_wr_buffer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;
  int   txn_id;

  axil_wr_buffer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) s_if ();
  axil_wr_buffer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m_if ();

  axil_wr_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .s_axil (s_if),
    .m_axil (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s (txn %0d): observed %0h expected %0h", tag, txn_id, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    s_if.awvalid = 1'b0; s_if.awaddr = '0; s_if.awprot = '0;
    s_if.wvalid  = 1'b0; s_if.wdata  = '0; s_if.wstrb  = '0;
    s_if.bready  = 1'b0;
    m_if.awready = 1'b0; m_if.wready = 1'b0;
    m_if.bvalid  = 1'b0; m_if.bresp  = 2'b00;
  endtask

  // Reset values of every output
  task automatic chk_reset_values(input string tag);
    chk({tag, " s_awready"}, s_if.awready, 1'b1);
    chk({tag, " s_wready"},  s_if.wready,  1'b1);
    chk({tag, " s_bvalid"},  s_if.bvalid,  1'b0);
    chk({tag, " s_bresp"},   s_if.bresp,   2'b00);
    chk({tag, " m_awvalid"}, m_if.awvalid, 1'b0);
    chk({tag, " m_wvalid"},  m_if.wvalid,  1'b0);
    chk({tag, " m_bready"},  m_if.bready,  1'b0);
    chk({tag, " m_awaddr"},  m_if.awaddr,  32'h0);
    chk({tag, " m_awprot"},  m_if.awprot,  3'h0);
    chk({tag, " m_wdata"},   m_if.wdata,   32'h0);
    chk({tag, " m_wstrb"},   m_if.wstrb,   4'h0);
  endtask

  // One complete write. Called at posedge+1. Delays: upstream AW/W start
  // cycle, downstream ready stall (cycles of valid seen before ready), B delay
  // after both downstream handshakes, upstream bready stall. The model
  // tracks only which handshakes have happened and derives every expected
  // output from that.
  task automatic run_txn(input logic [31:0] addr, input logic [2:0] prot,
                         input logic [31:0] data, input logic [3:0] strb,
                         input int aw_dly, input int w_dly,
                         input int maw_dly, input int mw_dly, input int b_dly,
                         input logic [1:0] resp, input int sb_dly, input bit spur,
                         output int cyc);
    bit aw_s, w_s, maw_d, mw_d, b_d, sb_d;
    bit aw_hs, w_hs, maw_hs, mw_hs, b_hs, sb_hs;
    bit exp_maw, exp_mw, exp_mb;
    int maw_cnt, mw_cnt, b_cnt, sb_cnt;
    aw_s = 0; w_s = 0; maw_d = 0; mw_d = 0; b_d = 0; sb_d = 0;
    maw_cnt = 0; mw_cnt = 0; b_cnt = 0; sb_cnt = 0;
    cyc = 0;
    while (!sb_d && cyc < 200) begin
      exp_maw = aw_s && w_s && !maw_d;
      exp_mw  = aw_s && w_s && !mw_d;
      exp_mb  = maw_d && mw_d && !b_d;
      chk("s_awready", s_if.awready, !aw_s);
      chk("s_wready",  s_if.wready,  !w_s);
      chk("m_awvalid", m_if.awvalid, exp_maw);
      chk("m_wvalid",  m_if.wvalid,  exp_mw);
      chk("m_bready",  m_if.bready,  exp_mb);
      chk("s_bvalid",  s_if.bvalid,  b_d);
      if (exp_maw) begin
        chk("m_awaddr", m_if.awaddr, addr);
        chk("m_awprot", m_if.awprot, prot);
      end
      if (exp_mw) begin
        chk("m_wdata", m_if.wdata, data);
        chk("m_wstrb", m_if.wstrb, strb);
      end
      if (b_d) chk("s_bresp", s_if.bresp, resp);

      s_if.awvalid = !aw_s && (cyc >= aw_dly);
      s_if.awaddr  = s_if.awvalid ? addr : 32'($urandom());
      s_if.awprot  = s_if.awvalid ? prot : 3'($urandom());
      s_if.wvalid  = !w_s && (cyc >= w_dly);
      s_if.wdata   = s_if.wvalid ? data : 32'($urandom());
      s_if.wstrb   = s_if.wvalid ? strb : 4'($urandom());
      m_if.awready = (maw_cnt >= maw_dly);
      m_if.wready  = (mw_cnt >= mw_dly);
      if (exp_mb) begin
        m_if.bvalid = (b_cnt >= b_dly);
        m_if.bresp  = m_if.bvalid ? resp : 2'($urandom());
      end else begin
        m_if.bvalid = spur;
        m_if.bresp  = 2'($urandom());
      end
      s_if.bready = b_d && (sb_cnt >= sb_dly);

      aw_hs  = s_if.awvalid;
      w_hs   = s_if.wvalid;
      maw_hs = exp_maw && m_if.awready;
      mw_hs  = exp_mw && m_if.wready;
      b_hs   = exp_mb && m_if.bvalid;
      sb_hs  = s_if.bready;

      @(posedge clk); #1;
      if (exp_maw) maw_cnt++;
      if (exp_mw)  mw_cnt++;
      if (exp_mb)  b_cnt++;
      if (b_d)     sb_cnt++;
      aw_s  = aw_s  || aw_hs;
      w_s   = w_s   || w_hs;
      maw_d = maw_d || maw_hs;
      mw_d  = mw_d  || mw_hs;
      b_d   = b_d   || b_hs;
      sb_d  = sb_d  || sb_hs;
      cyc++;
    end
    chk("completed", sb_d, 1'b1);
    idle_inputs();
    chk("post s_awready", s_if.awready, 1'b1);
    chk("post s_wready",  s_if.wready,  1'b1);
    chk("post s_bvalid",  s_if.bvalid,  1'b0);
    $display("txn %0d addr=%08h prot=%0d data=%08h strb=%h resp=%0d cycles=%0d",
             txn_id, addr, prot, data, strb, resp, cyc);
    txn_id++;
  endtask

  initial begin
    int cyc;
    n_cmp = 0; n_mis = 0; txn_id = 0;
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_values("reset");

    // Back-to-back ready: minimum latency of 4 cycles
    run_txn(32'h0000_0010, 3'd0, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 1'b0, cyc);
    chk("min latency", cyc, 4);

    // W five cycles ahead of AW
    run_txn(32'h0000_0020, 3'd2, 32'h1234_5678, 4'h3, 5, 0, 0, 0, 0, 2'b00, 0, 1'b0, cyc);

    // AW ahead of W
    run_txn(32'h0000_0030, 3'd1, 32'hCAFE_F00D, 4'hC, 0, 3, 0, 0, 1, 2'b01, 0, 1'b0, cyc);

    // Downstream split stall: W ready held low 6 cycles
    run_txn(32'h0000_0040, 3'd5, 32'hA5A5_5A5A, 4'h9, 0, 0, 0, 6, 0, 2'b00, 0, 1'b0, cyc);

    // Error response with upstream backpressure, spurious B outside RESP
    run_txn(32'h0000_0050, 3'd7, 32'h0BAD_0BAD, 4'hF, 0, 0, 2, 0, 2, 2'b10, 4, 1'b1, cyc);

    // All four response codes
    for (int r = 0; r < 4; r++)
      run_txn(32'h100 + 32'(r * 4), 3'(r), 32'h5555_0000 + 32'(r), 4'h1 << r,
              0, 0, r, 3 - r, r, 2'(r), r, r[0], cyc);

    // Asynchronous reset mid-transaction, in ISSUE with m_awvalid high
    s_if.awvalid = 1'b1; s_if.awaddr = 32'h0000_0055; s_if.awprot = 3'd3;
    s_if.wvalid  = 1'b1; s_if.wdata  = 32'h7777_7777; s_if.wstrb  = 4'hF;
    @(posedge clk); #1;
    idle_inputs();
    chk("pre-reset m_awvalid", m_if.awvalid, 1'b1);
    chk("pre-reset m_awaddr",  m_if.awaddr,  32'h0000_0055);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_reset_values("async reset");
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_values("after reset");
    run_txn(32'h0000_0060, 3'd4, 32'h0F0F_F0F0, 4'h6, 0, 0, 0, 0, 0, 2'b00, 0, 1'b0, cyc);

    // Randomized writes
    for (int i = 0; i < 30; i++)
      run_txn(32'($urandom()), 3'($urandom()), 32'($urandom()), 4'($urandom()),
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              2'($urandom()), $urandom_range(0, 3), 1'($urandom()), cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
